// File: rtl/friscv_rd_arbiter_if.sv
// Write-back bus between the execution units and the register file port.
// Three no-backpressure request channels (alu, mem, m), one write port,
// per-source almost-full flags and a sticky overflow flag.
interface friscv_rd_arbiter_if #(
    parameter int unsigned XLEN = 32
);

    logic                alu_rd_wr;
    logic [4:0]          alu_rd_addr;
    logic [XLEN-1:0]     alu_rd_val;
    logic [XLEN/8-1:0]   alu_rd_strb;
    logic                alu_afull;

    logic                mem_rd_wr;
    logic [4:0]          mem_rd_addr;
    logic [XLEN-1:0]     mem_rd_val;
    logic [XLEN/8-1:0]   mem_rd_strb;
    logic                mem_afull;

    logic                m_rd_wr;
    logic [4:0]          m_rd_addr;
    logic [XLEN-1:0]     m_rd_val;
    logic [XLEN/8-1:0]   m_rd_strb;
    logic                m_afull;

    logic                rd_wr;
    logic [4:0]          rd_addr;
    logic [XLEN-1:0]     rd_val;
    logic [XLEN/8-1:0]   rd_strb;
    logic                ovf_err;

    // Execution-unit / register-file side
    modport master (
        output alu_rd_wr, alu_rd_addr, alu_rd_val, alu_rd_strb,
        output mem_rd_wr, mem_rd_addr, mem_rd_val, mem_rd_strb,
        output m_rd_wr, m_rd_addr, m_rd_val, m_rd_strb,
        input  alu_afull, mem_afull, m_afull,
        input  rd_wr, rd_addr, rd_val, rd_strb, ovf_err
    );

    // Arbiter side
    modport slave (
        input  alu_rd_wr, alu_rd_addr, alu_rd_val, alu_rd_strb,
        input  mem_rd_wr, mem_rd_addr, mem_rd_val, mem_rd_strb,
        input  m_rd_wr, m_rd_addr, m_rd_val, m_rd_strb,
        output alu_afull, mem_afull, m_afull,
        output rd_wr, rd_addr, rd_val, rd_strb, ovf_err
    );

endinterface

// File: rtl/friscv_rd_arbiter.sv
// Write-back arbiter: one FIFO per execution unit (alu=0, mem=1, m=2),
// drained round-robin into a single registered register-file write port.
// Optional feature: define FRISCV_RDARB_BYPASS_EN to let a lone request
// skip its FIFO when every FIFO is empty (latency 1 instead of 2).
module friscv_rd_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 srst,
    friscv_rd_arbiter_if.slave   bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = XLEN / 8;
    localparam logic [CW-1:0] CntFull  = CW'(DEPTH);
    localparam logic [CW-1:0] CntAfull = CW'(DEPTH - 1);

    logic [2:0]       req_wr;
    logic [4:0]       req_addr [3];
    logic [XLEN-1:0]  req_val  [3];
    logic [SW-1:0]    req_strb [3];

    logic [4:0]       fifo_addr [3][DEPTH];
    logic [XLEN-1:0]  fifo_val  [3][DEPTH];
    logic [SW-1:0]    fifo_strb [3][DEPTH];
    logic [AW-1:0]    wptr [3];
    logic [AW-1:0]    rptr [3];
    logic [CW-1:0]    cnt  [3];
    logic [1:0]       lg;

    logic [2:0]       req_ok, nonempty, push, pop, accept, overflow;
    logic             grant_vld, byp_vld;
    logic [1:0]       grant_idx, byp_idx;
    logic [4:0]       nxt_addr;
    logic [XLEN-1:0]  nxt_val;
    logic [SW-1:0]    nxt_strb;

    logic             rd_wr_q, ovf_err_q;
    logic [4:0]       rd_addr_q;
    logic [XLEN-1:0]  rd_val_q;
    logic [SW-1:0]    rd_strb_q;

    // Search lg+1, lg+2, lg (mod 3); returns {valid, index}
    function automatic logic [2:0] rr_pick(input logic [2:0] mask, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        idx = last;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (!res[2] && mask[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign req_wr      = {bus.m_rd_wr, bus.mem_rd_wr, bus.alu_rd_wr};
    assign req_addr[0] = bus.alu_rd_addr;
    assign req_addr[1] = bus.mem_rd_addr;
    assign req_addr[2] = bus.m_rd_addr;
    assign req_val[0]  = bus.alu_rd_val;
    assign req_val[1]  = bus.mem_rd_val;
    assign req_val[2]  = bus.m_rd_val;
    assign req_strb[0] = bus.alu_rd_strb;
    assign req_strb[1] = bus.mem_rd_strb;
    assign req_strb[2] = bus.m_rd_strb;

    // Grant, bypass, push/pop and overflow decisions for this cycle
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            req_ok[i]   = req_wr[i] && (req_addr[i] != 5'd0);  // x0 writes are dropped
            nonempty[i] = (cnt[i] != '0);
        end
        {grant_vld, grant_idx} = rr_pick(nonempty, lg);
`ifdef FRISCV_RDARB_BYPASS_EN
        {byp_vld, byp_idx} = (nonempty == 3'b000) ? rr_pick(req_ok, lg) : 3'b000;
`else
        byp_vld = 1'b0;
        byp_idx = 2'd0;
`endif
        for (int i = 0; i < 3; i++) begin
            pop[i]      = grant_vld && (grant_idx == 2'(i));
            push[i]     = req_ok[i] && !(byp_vld && (byp_idx == 2'(i)));
            // A pop in the same cycle frees the slot a full FIFO needs
            accept[i]   = push[i] && ((cnt[i] != CntFull) || pop[i]);
            overflow[i] = push[i] && (cnt[i] == CntFull) && !pop[i];
        end
    end

    // Data for the write port: FIFO head of the grantee, else the bypassed request
    always_comb begin
        if (grant_vld) begin
            nxt_addr = fifo_addr[grant_idx][rptr[grant_idx]];
            nxt_val  = fifo_val[grant_idx][rptr[grant_idx]];
            nxt_strb = fifo_strb[grant_idx][rptr[grant_idx]];
        end else begin
            nxt_addr = req_addr[byp_idx];
            nxt_val  = req_val[byp_idx];
            nxt_strb = req_strb[byp_idx];
        end
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge aclk) begin
        for (int i = 0; i < 3; i++) begin
            if (accept[i]) begin
                fifo_addr[i][wptr[i]] <= req_addr[i];
                fifo_val[i][wptr[i]]  <= req_val[i];
                fifo_strb[i][wptr[i]] <= req_strb[i];
            end
        end
    end

    // Pointers, counts, round-robin state and the registered write port
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 3; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            lg        <= 2'd2;
            rd_wr_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_val_q  <= '0;
            rd_strb_q <= '0;
            ovf_err_q <= 1'b0;
        end else if (srst) begin
            for (int i = 0; i < 3; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            lg        <= 2'd2;
            rd_wr_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_val_q  <= '0;
            rd_strb_q <= '0;
            ovf_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (accept[i]) wptr[i] <= wptr[i] + AW'(1);
                if (pop[i])    rptr[i] <= rptr[i] + AW'(1);
                cnt[i] <= cnt[i] + CW'(accept[i]) - CW'(pop[i]);
            end
            rd_wr_q <= grant_vld || byp_vld;
            if (grant_vld || byp_vld) begin
                lg        <= grant_vld ? grant_idx : byp_idx;
                rd_addr_q <= nxt_addr;
                rd_val_q  <= nxt_val;
                rd_strb_q <= nxt_strb;
            end
            if (|overflow) ovf_err_q <= 1'b1;
        end
    end

    assign bus.alu_afull = (cnt[0] >= CntAfull);
    assign bus.mem_afull = (cnt[1] >= CntAfull);
    assign bus.m_afull   = (cnt[2] >= CntAfull);
    assign bus.rd_wr     = rd_wr_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_val    = rd_val_q;
    assign bus.rd_strb   = rd_strb_q;
    assign bus.ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_friscv_rd_arbiter.sv
// Bench for friscv_rd_arbiter (default build, FIFO path only, DEPTH=4).
// Each step drives one cycle of requests, then checks the write port,
// afull flags and ovf_err just after the following rising edge.
module tb_friscv_rd_arbiter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic srst = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 aclk = ~aclk;

    friscv_rd_arbiter_if #(.XLEN(XLEN)) bus ();

    friscv_rd_arbiter #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .bus     (bus)
    );

    typedef struct {
        logic       srst;
        logic [2:0] wr;      // {m, mem, alu}
        logic [4:0] a0, a1, a2;
        logic       e_wr;
        logic [4:0] e_addr;  // 0 means reset value (val/strb 0)
        int         e_src;
        logic [2:0] e_afull; // {m, mem, alu}
        logic       e_ovf;
    } vec_t;

    vec_t tv[$];

    // Payload is a function of (source, addr) so the data path is checked too
    function automatic logic [31:0] val_of(input int s, input logic [4:0] a);
        return {4'(s + 1), 23'd0, a};
    endfunction

    function automatic logic [3:0] strb_of(input int s, input logic [4:0] a);
        return 4'(a) ^ 4'(s);
    endfunction

    function automatic void add(input logic s, input logic [2:0] wr,
                                input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                input logic e_wr, input logic [4:0] e_addr, input int e_src,
                                input logic [2:0] e_afull, input logic e_ovf);
        vec_t v;
        v.srst = s; v.wr = wr; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.e_wr = e_wr; v.e_addr = e_addr; v.e_src = e_src;
        v.e_afull = e_afull; v.e_ovf = e_ovf;
        tv.push_back(v);
    endfunction

    task automatic drive(input logic [2:0] wr, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2);
        bus.alu_rd_wr   = wr[0];
        bus.alu_rd_addr = a0;
        bus.alu_rd_val  = val_of(0, a0);
        bus.alu_rd_strb = strb_of(0, a0);
        bus.mem_rd_wr   = wr[1];
        bus.mem_rd_addr = a1;
        bus.mem_rd_val  = val_of(1, a1);
        bus.mem_rd_strb = strb_of(1, a1);
        bus.m_rd_wr     = wr[2];
        bus.m_rd_addr   = a2;
        bus.m_rd_val    = val_of(2, a2);
        bus.m_rd_strb   = strb_of(2, a2);
    endtask

    task automatic check(input string tag, input logic e_wr, input logic [4:0] e_addr,
                         input int e_src, input logic [2:0] e_afull, input logic e_ovf);
        logic [31:0] e_val;
        logic [3:0]  e_strb;
        logic [2:0]  g_afull;
        e_val   = (e_addr == 5'd0) ? 32'd0 : val_of(e_src, e_addr);
        e_strb  = (e_addr == 5'd0) ? 4'd0 : strb_of(e_src, e_addr);
        g_afull = {bus.m_afull, bus.mem_afull, bus.alu_afull};
        n_chk++;
        if (bus.rd_wr === e_wr && bus.rd_addr === e_addr && bus.rd_val === e_val &&
            bus.rd_strb === e_strb && g_afull === e_afull && bus.ovf_err === e_ovf) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got wr=%b addr=%0d val=%h strb=%h afull=%b ovf=%b, want wr=%b addr=%0d val=%h strb=%h afull=%b ovf=%b",
                     tag, bus.rd_wr, bus.rd_addr, bus.rd_val, bus.rd_strb, g_afull, bus.ovf_err,
                     e_wr, e_addr, e_val, e_strb, e_afull, e_ovf);
        end
    endtask

    task automatic step(input string tag, input logic s, input logic [2:0] wr,
                        input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                        input logic e_wr, input logic [4:0] e_addr, input int e_src,
                        input logic [2:0] e_afull, input logic e_ovf);
        srst = s;
        drive(wr, a0, a1, a2);
        @(posedge aclk);
        #1;
        check(tag, e_wr, e_addr, e_src, e_afull, e_ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running want finished");
        $fatal(1);
    end

    initial begin
        // Single write, latency 2, one-cycle pulse
        add(0, 3'b001, 5, 0, 0,   0, 0, 0, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   1, 5, 0, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   0, 5, 0, 3'b000, 0);
        // x0 filter on m
        add(0, 3'b100, 0, 0, 0,   0, 5, 0, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   0, 5, 0, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   0, 5, 0, 3'b000, 0);
        // Round-robin with lg=0 -> 2, 3, 1
        add(0, 3'b111, 1, 2, 3,   0, 5, 0, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   1, 2, 1, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   1, 3, 2, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   1, 1, 0, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   0, 1, 0, 3'b000, 0);
        // Move lg to 2 via a lone m write, then round-robin -> 1, 2, 3
        add(0, 3'b100, 0, 0, 7,   0, 1, 0, 3'b000, 0);
        add(0, 3'b111, 1, 2, 3,   1, 7, 2, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   1, 1, 0, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   1, 2, 1, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   1, 3, 2, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   0, 3, 2, 3'b000, 0);
        // All sources write 6 cycles ignoring afull; m overflows on the 6th
        add(0, 3'b111, 8, 14, 20,  0, 3, 2, 3'b000, 0);
        add(0, 3'b111, 9, 15, 21,  1, 8, 0, 3'b000, 0);
        add(0, 3'b111, 10, 16, 22, 1, 14, 1, 3'b100, 0);
        add(0, 3'b111, 11, 17, 23, 1, 20, 2, 3'b111, 0);
        add(0, 3'b111, 12, 18, 24, 1, 9, 0, 3'b111, 0);
        add(0, 3'b111, 13, 19, 25, 1, 15, 1, 3'b111, 1);
        // Drain: 4 entries left per source, in order, m entry 25 lost
        add(0, 3'b000, 0, 0, 0,   1, 21, 2, 3'b111, 1);
        add(0, 3'b000, 0, 0, 0,   1, 10, 0, 3'b111, 1);
        add(0, 3'b000, 0, 0, 0,   1, 16, 1, 3'b111, 1);
        add(0, 3'b000, 0, 0, 0,   1, 22, 2, 3'b011, 1);
        add(0, 3'b000, 0, 0, 0,   1, 11, 0, 3'b010, 1);
        add(0, 3'b000, 0, 0, 0,   1, 17, 1, 3'b000, 1);
        add(0, 3'b000, 0, 0, 0,   1, 23, 2, 3'b000, 1);
        add(0, 3'b000, 0, 0, 0,   1, 12, 0, 3'b000, 1);
        add(0, 3'b000, 0, 0, 0,   1, 18, 1, 3'b000, 1);
        add(0, 3'b000, 0, 0, 0,   1, 24, 2, 3'b000, 1);
        add(0, 3'b000, 0, 0, 0,   1, 13, 0, 3'b000, 1);
        add(0, 3'b000, 0, 0, 0,   1, 19, 1, 3'b000, 1);
        add(0, 3'b000, 0, 0, 0,   0, 19, 1, 3'b000, 1);
        // 3 entries pending, srst for one cycle drops them and clears ovf
        add(0, 3'b111, 4, 5, 6,   0, 19, 1, 3'b000, 1);
        add(1, 3'b000, 0, 0, 0,   0, 0, 0, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   0, 0, 0, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   0, 0, 0, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   0, 0, 0, 3'b000, 0);
        // lg back to 2 after srst: alu first
        add(0, 3'b101, 9, 0, 10,  0, 0, 0, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   1, 9, 0, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   1, 10, 2, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0,   0, 10, 2, 3'b000, 0);

        drive(3'b000, 0, 0, 0);
        repeat (2) @(posedge aclk);
        #1;
        check("reset", 0, 0, 0, 3'b000, 0);
        aresetn = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            step($sformatf("vec%0d", i), tv[i].srst, tv[i].wr, tv[i].a0, tv[i].a1, tv[i].a2,
                 tv[i].e_wr, tv[i].e_addr, tv[i].e_src, tv[i].e_afull, tv[i].e_ovf);
        end

        // Push into the full mem FIFO in the cycle it is granted: accepted, no overflow
        step("pp_fill1", 0, 3'b111, 1, 6, 11,  0, 10, 2, 3'b000, 0);
        step("pp_fill2", 0, 3'b111, 2, 7, 12,  1, 1, 0, 3'b000, 0);
        step("pp_fill3", 0, 3'b111, 3, 8, 13,  1, 6, 1, 3'b100, 0);
        step("pp_fill4", 0, 3'b111, 4, 9, 14,  1, 11, 2, 3'b111, 0);
        step("pp_fill5", 0, 3'b111, 5, 10, 15, 1, 2, 0, 3'b111, 0);
        step("pp_full",  0, 3'b010, 0, 16, 0,  1, 7, 1, 3'b111, 0);
        step("pp_d1",  0, 3'b000, 0, 0, 0, 1, 12, 2, 3'b111, 0);
        step("pp_d2",  0, 3'b000, 0, 0, 0, 1, 3, 0, 3'b110, 0);
        step("pp_d3",  0, 3'b000, 0, 0, 0, 1, 8, 1, 3'b110, 0);
        step("pp_d4",  0, 3'b000, 0, 0, 0, 1, 13, 2, 3'b010, 0);
        step("pp_d5",  0, 3'b000, 0, 0, 0, 1, 4, 0, 3'b010, 0);
        step("pp_d6",  0, 3'b000, 0, 0, 0, 1, 9, 1, 3'b000, 0);
        step("pp_d7",  0, 3'b000, 0, 0, 0, 1, 14, 2, 3'b000, 0);
        step("pp_d8",  0, 3'b000, 0, 0, 0, 1, 5, 0, 3'b000, 0);
        step("pp_d9",  0, 3'b000, 0, 0, 0, 1, 10, 1, 3'b000, 0);
        step("pp_d10", 0, 3'b000, 0, 0, 0, 1, 15, 2, 3'b000, 0);
        step("pp_d11", 0, 3'b000, 0, 0, 0, 1, 16, 1, 3'b000, 0);
        step("pp_d12", 0, 3'b000, 0, 0, 0, 0, 16, 1, 3'b000, 0);

        // Asynchronous reset mid-operation: outputs clear without a clock edge
        step("ar_push", 0, 3'b111, 1, 2, 3, 0, 16, 1, 3'b000, 0);
        drive(3'b000, 0, 0, 0);
        #2;
        aresetn = 1'b0;
        #1;
        check("ar_async", 0, 0, 0, 3'b000, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        step("ar_idle1", 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        step("ar_idle2", 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        step("ar_idle3", 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
